multicycle_core: RTL and testbench

Multi-cycle TinyRISC core: the successor to the single-cycle processor. It executes the same 21-instruction ISA through a state machine (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) over one shared instruction/data memory port with a valid/ready handshake, so it tolerates wait-state memories. Address width and reset vector are parametrised. It sits at the top of the CPU subsystem, directly on the memory/bus interconnect.

---
 rtl/multicycle_core_if.sv | 23 ++
 rtl/multicycle_core.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Shared instruction/data memory port of the multicycle core.
// A transfer completes on a rising edge where mem_req and mem_ready are both 1.
interface multicycle_core_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    // Core side drives the request, memory side answers it.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle TinyRISC core: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT over one
// shared memory port with a valid/ready handshake.
// Optional feature macro: MULDIV_EN (mul/div/mod); without it opcodes 2-4 halt.
module multicycle_core #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,      // asynchronous, active low
    multicycle_core_if.master   mem,
    output logic                retire,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,
                           OP_DIV = 5'd3,  OP_MOD = 5'd4,  OP_CMP = 5'd5,
                           OP_AND = 5'd6,  OP_OR  = 5'd7,  OP_NOT = 5'd8,
                           OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11,
                           OP_ASR = 5'd12, OP_NOP = 5'd13, OP_LD  = 5'd14,
                           OP_ST  = 5'd15, OP_BEQ = 5'd16, OP_BGT = 5'd17,
                           OP_B   = 5'd18, OP_CALL = 5'd19, OP_RET = 5'd20;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q;
    logic [31:0]       a_q, b_q, sd_q;   // operands and store data, latched in DECODE
    logic [31:0]       alu_q;
    logic [31:0]       mdr_q;
    logic              fe_q, fgt_q;
    logic [31:0]       rf_q [16];

    logic [4:0]        opc;
    logic              iflag;
    logic [3:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic [31:0]       alu_res;
    logic              legal;
    logic              is_st, is_call;
    logic [ADDR_W-1:0] pc4, tgt;

    assign opc     = ir_q[31:27];
    assign iflag   = ir_q[26];
    assign rd      = ir_q[25:22];
    assign rs1     = ir_q[21:18];
    assign rs2     = ir_q[17:14];
    assign is_st   = (opc == OP_ST);
    assign is_call = (opc == OP_CALL);
    assign pc4     = pc_q + ADDR_W'(4);
    assign tgt     = ADDR_W'(32'(pc_q) + {{3{ir_q[26]}}, ir_q[26:0], 2'b00});
    assign pc_out  = pc_q;

    // Immediate formation from the modifier bits.
    always_comb begin
        imm = {{16{ir_q[15]}}, ir_q[15:0]};
        case (ir_q[17:16])
            2'b01:   imm = {16'h0000, ir_q[15:0]};
            2'b10:   imm = {ir_q[15:0], 16'h0000};
            default: imm = {{16{ir_q[15]}}, ir_q[15:0]};
        endcase
    end

    // Opcode legality; mul/div/mod only exist when the divider is built.
    always_comb begin
`ifdef MULDIV_EN
        legal = (opc <= OP_RET);
`else
        legal = (opc <= OP_RET) && (opc != OP_MUL) && (opc != OP_DIV) && (opc != OP_MOD);
`endif
    end

    // ALU; ld/st reuse the adder for address generation.
    always_comb begin
        alu_res = '0;
        case (opc)
            OP_ADD, OP_LD, OP_ST: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOT: alu_res = ~b_q;
            OP_MOV: alu_res = b_q;
            OP_LSL: alu_res = a_q << b_q[4:0];
            OP_LSR: alu_res = a_q >> b_q[4:0];
            OP_ASR: alu_res = 32'($signed(a_q) >>> b_q[4:0]);
`ifdef MULDIV_EN
            OP_MUL: alu_res = a_q * b_q;
            OP_DIV: begin
                if (b_q == '0)
                    alu_res = 32'hFFFF_FFFF;
                else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)
                    alu_res = 32'h8000_0000;
                else
                    alu_res = 32'($signed(a_q) / $signed(b_q));
            end
            OP_MOD: begin
                if (b_q == '0)
                    alu_res = a_q;
                else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)
                    alu_res = '0;
                else
                    alu_res = 32'($signed(a_q) % $signed(b_q));
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, PC update and all port outputs (from state and registers).
    // A store retires in its completing MEM cycle, so retire there follows
    // mem_ready; the memory-side outputs never depend on it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        retire        = 1'b0;
        halted        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_q;
                if (mem.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (opc)
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_NOP, OP_CMP: begin
                        retire = 1'b1; pc_d = pc4; state_d = S_FETCH;
                    end
                    OP_BEQ: begin
                        retire = 1'b1; pc_d = fe_q ? tgt : pc4; state_d = S_FETCH;
                    end
                    OP_BGT: begin
                        retire = 1'b1; pc_d = fgt_q ? tgt : pc4; state_d = S_FETCH;
                    end
                    OP_B: begin
                        retire = 1'b1; pc_d = tgt; state_d = S_FETCH;
                    end
                    OP_RET: begin
                        retire = 1'b1; pc_d = rf_q[15][ADDR_W-1:0]; state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = is_st;
                mem.mem_addr  = alu_q[ADDR_W-1:0] & ~ADDR_W'(3);
                mem.mem_wdata = is_st ? sd_q : '0;
                if (mem.mem_ready) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        pc_d    = pc4;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                pc_d    = is_call ? tgt : pc4;
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: IR, operands, ALU/MDR, flags and register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sd_q  <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            fe_q  <= 1'b0;
            fgt_q <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem.mem_ready) ir_q <= mem.mem_rdata;
                S_DECODE: begin
                    a_q  <= rf_q[rs1];
                    b_q  <= iflag ? imm : rf_q[rs2];
                    sd_q <= rf_q[rd];
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (opc == OP_CMP) begin
                        fe_q  <= (a_q == b_q);
                        fgt_q <= ($signed(a_q) > $signed(b_q));
                    end
                end
                S_MEM: if (mem.mem_ready && !is_st) mdr_q <= mem.mem_rdata;
                S_WB: begin
                    if (is_call)               rf_q[15] <= 32'(pc4);
                    else if (opc == OP_LD)     rf_q[rd] <= mdr_q;
                    else                       rf_q[rd] <= alu_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: table-driven ALU vectors plus
// hand-written sequences, with a store scoreboard fed by a memory monitor.
module tb_multicycle_core;
    localparam int unsigned   AW  = 32;
    localparam logic [AW-1:0] RPC = '0;
    localparam logic [31:0]   HLT = 32'hF800_0000;   // opcode 31

    localparam logic [4:0] T_ADD = 5'd0,  T_SUB = 5'd1,  T_MUL = 5'd2,
                           T_CMP = 5'd5,  T_AND = 5'd6,  T_OR  = 5'd7,
                           T_NOT = 5'd8,  T_MOV = 5'd9,  T_LSL = 5'd10,
                           T_LSR = 5'd11, T_ASR = 5'd12, T_NOP = 5'd13,
                           T_LD  = 5'd14, T_ST  = 5'd15, T_BEQ = 5'd16,
                           T_BGT = 5'd17, T_CALL = 5'd19, T_RET = 5'd20;
`ifdef MULDIV_EN
    localparam logic [4:0] T_DIV = 5'd3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          retire, halted;
    logic [AW-1:0] pc_out;

    multicycle_core_if #(.ADDR_W(AW)) bus();

    multicycle_core #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .mem(bus),
        .retire(retire), .halted(halted), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [0:1023];
    int cyc;
    int st_lo = 1, st_hi = 0;    // ready held low in cycles st_lo..st_hi

    assign bus.mem_ready = !(((cyc + 1) >= st_lo) && ((cyc + 1) <= st_hi));
    assign bus.mem_rdata = mem_arr[bus.mem_addr[11:2]];

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0; else cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
    st_t         sb[$];
    int          ret_q[$];
    logic [31:0] ftr[$];
    int n_vec = 0, n_err = 0;

    // Monitor: retire cycles, fetch trace, and store scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (retire) ret_q.push_back(cyc + 1);
            if (bus.mem_req && bus.mem_ready && !bus.mem_we) ftr.push_back(bus.mem_addr);
            if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL store_unexpected: got addr %h data %h, required none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    st_t e;
                    e = sb.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                        n_err++;
                        $display("FAIL store: got addr %h data %h, required addr %h data %h",
                                 bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ei(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [1:0] md,
                                       input logic [15:0] imm);
        return {op, 1'b1, rd, rs1, md, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'b0};
    endfunction

    function automatic logic [31:0] eb(input logic [4:0] op, input logic [26:0] off);
        return {op, off};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic prep();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = HLT;
        sb.delete(); ret_q.delete(); ftr.delete();
        st_lo = 1; st_hi = 0;
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_halted"}, {31'b0, halted}, 32'd1);
        chk({nm, "_req_after_halt"}, {31'b0, bus.mem_req}, 32'd0);
        chk({nm, "_stores_pending"}, sb.size(), 32'd0);
    endtask

    task automatic chk_ret(input string nm, input int idx, input int exp);
        chk(nm, (idx < ret_q.size()) ? ret_q[idx] : -1, exp);
    endtask

    function automatic int find_fetch(input logic [31:0] a);
        for (int i = 0; i < ftr.size(); i++) if (ftr[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [31:0] ftr_at(input int i);
        if (i >= 0 && i < ftr.size()) return ftr[i];
        return 32'hDEAD_DEAD;
    endfunction

    typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t vt[12];

    initial begin
        int k;
        vt[0]  = '{T_ADD, 32'd5,         32'd7,         32'd12};
        vt[1]  = '{T_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vt[2]  = '{T_ADD, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
        vt[3]  = '{T_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
        vt[4]  = '{T_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vt[5]  = '{T_NOT, 32'h0,         32'h1234_5678, 32'hEDCB_A987};
        vt[6]  = '{T_MOV, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[7]  = '{T_LSL, 32'd1,         32'd31,        32'h8000_0000};
        vt[8]  = '{T_LSL, 32'd1,         32'd33,        32'h0000_0002};
        vt[9]  = '{T_LSR, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vt[10] = '{T_ASR, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vt[11] = '{T_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF};

        // Reset values.
        prep();
        #2;
        chk("rst_req",    {31'b0, bus.mem_req}, 32'd0);
        chk("rst_we",     {31'b0, bus.mem_we},  32'd0);
        chk("rst_addr",   bus.mem_addr,         32'd0);
        chk("rst_wdata",  bus.mem_wdata,        32'd0);
        chk("rst_retire", {31'b0, retire},      32'd0);
        chk("rst_halted", {31'b0, halted},      32'd0);
        chk("rst_pc",     pc_out,               RPC);

        // Reset mid-fetch with ready low, then restart timing; opcode 31 halts.
        prep();
        st_lo = 1; st_hi = 1000;
        release_rst();
        #1 chk("c1_req", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        chk("c2_req", {31'b0, bus.mem_req}, 32'd1);
        #3 rst = 1'b0;
        #1 chk("async_req_drop", {31'b0, bus.mem_req}, 32'd0);
        st_hi = 0;
        release_rst();
        #1 chk("re_c1_req", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        chk("re_c2_req",  {31'b0, bus.mem_req}, 32'd1);
        chk("re_c2_addr", bus.mem_addr, RPC);
        wait_halt("op31", 20);
        chk("op31_retires", ret_q.size(), 32'd0);
        chk("op31_pc", pc_out, 32'h0);

        // Table-driven ALU vectors: load a, load b, op, store, halt.
        for (int v = 0; v < 12; v++) begin
            prep();
            mem_arr[0] = ei(T_MOV, 4'd1, 4'd0, 2'b10, vt[v].a[31:16]);
            mem_arr[1] = ei(T_OR,  4'd1, 4'd1, 2'b01, vt[v].a[15:0]);
            mem_arr[2] = ei(T_MOV, 4'd2, 4'd0, 2'b10, vt[v].b[31:16]);
            mem_arr[3] = ei(T_OR,  4'd2, 4'd2, 2'b01, vt[v].b[15:0]);
            mem_arr[4] = er(vt[v].op, 4'd3, 4'd1, 4'd2);
            mem_arr[5] = ei(T_ST,  4'd3, 4'd0, 2'b00, 16'h0100);
            push_st(32'h100, vt[v].exp);
            release_rst();
            wait_halt("vec", 60);
            chk("vec_halt_pc", pc_out, 32'h18);
        end

        // mov/add/st: store of 12 at 0 and retire every 4 cycles.
        prep();
        mem_arr[0] = ei(T_MOV, 4'd1, 4'd0, 2'b00, 16'd5);
        mem_arr[1] = ei(T_ADD, 4'd2, 4'd1, 2'b00, 16'd7);
        mem_arr[2] = ei(T_ST,  4'd2, 4'd0, 2'b00, 16'd0);
        push_st(32'h0, 32'd12);
        release_rst();
        wait_halt("seq", 40);
        chk("seq_retires", ret_q.size(), 32'd3);
        chk_ret("seq_ret0", 0, 5);
        chk_ret("seq_ret1", 1, 9);
        chk_ret("seq_ret2", 2, 13);

        // Three wait states on the first fetch.
        prep();
        mem_arr[0] = ei(T_MOV, 4'd1, 4'd0, 2'b00, 16'd5);
        mem_arr[1] = ei(T_ST,  4'd1, 4'd0, 2'b00, 16'h0100);
        push_st(32'h100, 32'd5);
        st_lo = 2; st_hi = 4;
        release_rst();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ws_req",  {31'b0, bus.mem_req}, 32'd1);
            chk("ws_we",   {31'b0, bus.mem_we},  32'd0);
            chk("ws_addr", bus.mem_addr, 32'h0);
        end
        wait_halt("ws", 40);
        chk_ret("ws_ret0", 0, 8);
        chk_ret("ws_ret1", 1, 12);

        // cmp equal, beq taken at 0x20 -> 0x2C, bgt not taken -> 0x30.
        prep();
        mem_arr[0]  = ei(T_MOV, 4'd1, 4'd0, 2'b00, 16'd5);
        mem_arr[1]  = ei(T_MOV, 4'd2, 4'd0, 2'b00, 16'd5);
        mem_arr[2]  = er(T_CMP, 4'd0, 4'd1, 4'd2);
        for (int i = 3; i < 8; i++) mem_arr[i] = eb(T_NOP, 27'd0);
        mem_arr[8]  = eb(T_BEQ, 27'd3);
        mem_arr[9]  = ei(T_ST,  4'd0, 4'd0, 2'b00, 16'h01F0);
        mem_arr[11] = eb(T_BGT, 27'd3);
        mem_arr[12] = ei(T_ST,  4'd1, 4'd0, 2'b00, 16'h0104);
        mem_arr[14] = ei(T_ST,  4'd0, 4'd0, 2'b00, 16'h01F0);
        push_st(32'h104, 32'd5);
        release_rst();
        wait_halt("br", 80);
        k = find_fetch(32'h20);
        chk("beq_next_fetch", ftr_at((k < 0) ? -9 : k + 1), 32'h2C);
        chk("bgt_next_fetch", ftr_at((k < 0) ? -9 : k + 2), 32'h30);

        // call +4 at 0x10 -> 0x20 with r15=0x14; ret -> 0x14.
        prep();
        for (int i = 0; i < 4; i++) mem_arr[i] = eb(T_NOP, 27'd0);
        mem_arr[4] = eb(T_CALL, 27'd4);
        mem_arr[5] = ei(T_ST, 4'd15, 4'd0, 2'b00, 16'h0108);
        mem_arr[8] = eb(T_RET, 27'd0);
        push_st(32'h108, 32'h14);
        release_rst();
        wait_halt("call", 80);
        k = find_fetch(32'h10);
        chk("call_next_fetch", ftr_at((k < 0) ? -9 : k + 1), 32'h20);
        chk("ret_next_fetch",  ftr_at((k < 0) ? -9 : k + 2), 32'h14);
        chk("call_retires", ret_q.size(), 32'd7);

        // ld takes 5 cycles, value forwarded to a store.
        prep();
        mem_arr[0]    = ei(T_LD, 4'd1, 4'd0, 2'b00, 16'h0200);
        mem_arr[1]    = ei(T_ST, 4'd1, 4'd0, 2'b00, 16'h010C);
        mem_arr[10'h80] = 32'hCAFE_F00D;
        push_st(32'h10C, 32'hCAFE_F00D);
        release_rst();
        wait_halt("ld", 40);
        chk_ret("ld_ret0", 0, 6);
        chk_ret("ld_ret1", 1, 10);

        // mul/div, or halt on mul when the divider is not built.
        prep();
        mem_arr[0] = ei(T_MOV, 4'd1, 4'd0, 2'b00, 16'd5);
        mem_arr[1] = ei(T_MUL, 4'd3, 4'd1, 2'b00, 16'hFFFE);
`ifdef MULDIV_EN
        mem_arr[2] = ei(T_ST,  4'd3, 4'd0, 2'b00, 16'h0100);
        mem_arr[3] = ei(T_DIV, 4'd4, 4'd1, 2'b00, 16'h0000);
        mem_arr[4] = ei(T_ST,  4'd4, 4'd0, 2'b00, 16'h0104);
        push_st(32'h100, 32'hFFFF_FFF6);
        push_st(32'h104, 32'hFFFF_FFFF);
        release_rst();
        wait_halt("muldiv", 60);
        chk("muldiv_halt_pc", pc_out, 32'h14);
`else
        mem_arr[2] = ei(T_ST,  4'd3, 4'd0, 2'b00, 16'h0100);
        release_rst();
        wait_halt("mul_illegal", 40);
        chk("mul_illegal_pc", pc_out, 32'h4);
        chk("mul_illegal_retires", ret_q.size(), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mul_halt_req", {31'b0, bus.mem_req}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
